// File: rtl/ttlock_key_ctrl_pkg.sv
// Shared types and sizing helpers for the TTLock key-application controller.
package ttlock_ctrl_pkg;

  localparam int KEY_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETTLE,
    RESP,
    LOCKOUT
  } ctrl_state_e;

  // Bits needed to hold any count 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ttlock_key_ctrl_if.sv
// Request/response handshake bundle between a query source and ttlock_key_ctrl.
interface ttlock_key_ctrl_if
  import ttlock_ctrl_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT
);

  logic             req_valid;
  logic             req_ready;
  logic [KEY_W-1:0] req_key;
  logic             req_expect;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_out;
  logic             rsp_match;

  modport master (
    output req_valid, req_key, req_expect, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_match
  );

  modport slave (
    input  req_valid, req_key, req_expect, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_match
  );

endinterface

// File: rtl/ttlock_key_ctrl_shifter.sv
// Serial key loader: load buffer feeding a shadow register LSB first.
// TTLOCK_KEY_SCRUB_EN: shadow is wiped once its contents have been handed off.
module ttlock_key_shifter
  import ttlock_ctrl_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic [KEY_W-1:0] shadow_q
);

  localparam int CW = cnt_w(KEY_W - 1);

  logic [KEY_W-1:0] load_buf;
  logic [CW-1:0]    bit_cnt;

  // The load edge already shifts bit 0, so the last bit lands KEY_W-1 edges
  // later and the full shadow is visible while done is high.
  assign done = busy && (bit_cnt == CW'(KEY_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_buf <= '0;
      shadow_q <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
    end else if (load) begin
      load_buf <= key_in >> 1;
      shadow_q <= {key_in[0], shadow_q[KEY_W-1:1]};
      bit_cnt  <= '0;
      busy     <= 1'b1;
    end else if (done) begin
      busy     <= 1'b0;
`ifdef TTLOCK_KEY_SCRUB_EN
      shadow_q <= '0;
`endif
    end else if (busy) begin
      load_buf <= load_buf >> 1;
      shadow_q <= {load_buf[0], shadow_q[KEY_W-1:1]};
      bit_cnt  <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ttlock_key_ctrl.sv
// Applies candidate keys to a TTLock-locked netlist, samples and grades its output.
// TTLOCK_KEY_SCRUB_EN: clear key_out on each response handshake.
module ttlock_key_ctrl
  import ttlock_ctrl_pkg::*;
#(
  parameter int KEY_W      = KEY_W_DEFAULT,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_FAIL   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ttlock_key_ctrl_if.slave           bus,
  output logic [KEY_W-1:0]           key_out,
  input  logic                       lock_out,
  output logic [cnt_w(MAX_FAIL)-1:0] fail_cnt,
  output logic                       locked
);

  localparam int FW = cnt_w(MAX_FAIL);
  localparam int SW = cnt_w(SETTLE_CYC);

  ctrl_state_e      state, state_nxt;
  logic [SW-1:0]    settle_cnt;
  logic             exp_q;
  logic             sh_busy, sh_done;
  logic [KEY_W-1:0] shadow_q;
  logic             accept, rsp_hs, settle_done;
  logic [FW-1:0]    fail_nxt;

  assign accept      = bus.req_valid && bus.req_ready;
  assign rsp_hs      = (state == RESP) && bus.rsp_ready;
  assign settle_done = (state == SETTLE) && (settle_cnt == SW'(SETTLE_CYC - 1));
  assign fail_nxt    = bus.rsp_match ? '0 : fail_cnt + FW'(1);

  ttlock_key_shifter #(.KEY_W(KEY_W)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .key_in   (bus.req_key),
    .busy     (sh_busy),
    .done     (sh_done),
    .shadow_q (shadow_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    locked        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = !sh_busy;
        if (bus.req_valid && !sh_busy) state_nxt = SHIFT;
      end
      SHIFT:   if (sh_done)     state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = RESP;
      RESP:    if (rsp_hs)      state_nxt = (fail_nxt == FW'(MAX_FAIL)) ? LOCKOUT : IDLE;
      LOCKOUT: locked = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // key_out only ever changes to a fully shifted key or to zero, never a partial one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out       <= '0;
      settle_cnt    <= '0;
      exp_q         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_out   <= 1'b0;
      bus.rsp_match <= 1'b0;
      fail_cnt      <= '0;
    end else begin
      if (accept) exp_q <= bus.req_expect;
      case (state)
        SHIFT: begin
          if (sh_done) begin
            key_out    <= shadow_q;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            bus.rsp_out   <= lock_out;
            bus.rsp_match <= (lock_out == exp_q);
            bus.rsp_valid <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        RESP: begin
          if (rsp_hs) begin
            bus.rsp_valid <= 1'b0;
            fail_cnt      <= fail_nxt;
`ifdef TTLOCK_KEY_SCRUB_EN
            key_out       <= '0;
`else
            if (fail_nxt == FW'(MAX_FAIL)) key_out <= '0;
`endif
          end
        end
        LOCKOUT: begin
          key_out       <= '0;
          bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ttlock_key_ctrl.sv
// Directed + randomized self-checking bench for ttlock_key_ctrl against a query-level model.
module tb_ttlock_key_ctrl;
  import ttlock_ctrl_pkg::*;

  localparam int KEY_W      = 32;
  localparam int SETTLE_CYC = 2;
  localparam int MAX_FAIL   = 8;
  localparam int LAT        = KEY_W + SETTLE_CYC;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [KEY_W-1:0]           key_out;
  logic                       lock_out = 1'b0;
  logic [cnt_w(MAX_FAIL)-1:0] fail_cnt;
  logic                       locked;

  ttlock_key_ctrl_if #(.KEY_W(KEY_W)) bus ();

  ttlock_key_ctrl #(
    .KEY_W      (KEY_W),
    .SETTLE_CYC (SETTLE_CYC),
    .MAX_FAIL   (MAX_FAIL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .key_out  (key_out),
    .lock_out (lock_out),
    .fail_cnt (fail_cnt),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Query-level reference: consecutive-miss count, lockout flag, key resident on the netlist.
  int               fail_m   = 0;
  bit               locked_m = 1'b0;
  logic [KEY_W-1:0] key_m    = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #1;
    fail_m   = 0;
    locked_m = 1'b0;
    key_m    = '0;
    checkOutput("rst_key_out",   key_out,       '0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_fail_cnt",  fail_cnt,      0);
    checkOutput("rst_locked",    locked,        0);
    checkOutput("rst_req_ready", bus.req_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One full query: request, shift/settle window, optional response stall, handshake.
  task automatic applyStimulus(input logic [KEY_W-1:0] key, input bit exp_bit,
                               input bit lock_val, input int hold);
    int   wait_cyc    = 0;
    int   first_valid = -1;
    bit   key_ok      = 1'b1;
    bit   busy_ok     = 1'b1;
    bit   stable_ok   = 1'b1;
    logic exp_match;
    exp_match = (lock_val == exp_bit);
    while (!bus.req_ready && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    if (!bus.req_ready) begin
      checkOutput("req_ready_timeout", 0, 1);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_key    = key;
    bus.req_expect = exp_bit;
    tick();
    bus.req_valid  = 1'b0;
    bus.req_key    = $urandom;
    bus.req_expect = 1'($urandom);
    for (int cyc = 1; cyc <= LAT; cyc++) begin
      lock_out = (cyc == LAT) ? lock_val : 1'($urandom);
      tick();
      if (bus.rsp_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (key_out !== ((cyc < KEY_W) ? key_m : key)) key_ok = 1'b0;
      if (bus.req_ready !== 1'b0) busy_ok = 1'b0;
    end
    checkOutput("rsp_latency",    first_valid,   LAT);
    checkOutput("key_out_window", key_ok,        1);
    checkOutput("req_ready_busy", busy_ok,       1);
    checkOutput("rsp_out",        bus.rsp_out,   lock_val);
    checkOutput("rsp_match",      bus.rsp_match, exp_match);
    checkOutput("key_applied",    key_out,       key);
    for (int h = 0; h < hold; h++) begin
      lock_out = 1'($urandom);
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_out !== lock_val ||
          bus.rsp_match !== exp_match || bus.req_ready !== 1'b0) stable_ok = 1'b0;
    end
    if (hold > 0) checkOutput("rsp_stall_stable", stable_ok, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    if (exp_match) fail_m = 0;
    else           fail_m++;
    if (fail_m == MAX_FAIL) begin
      locked_m = 1'b1;
      key_m    = '0;
    end else begin
`ifdef TTLOCK_KEY_SCRUB_EN
      key_m = '0;
`else
      key_m = key;
`endif
    end
    checkOutput("rsp_valid_clear", bus.rsp_valid, 0);
    checkOutput("fail_cnt",        fail_cnt,      fail_m);
    checkOutput("locked",          locked,        locked_m);
    checkOutput("key_after_hs",    key_out,       key_m);
    checkOutput("req_ready_after", bus.req_ready, !locked_m);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit lock_ok;
    bus.req_valid  = 1'b0;
    bus.req_key    = '0;
    bus.req_expect = 1'b0;
    bus.rsp_ready  = 1'b0;

    $display("[TB] reset and first directed query");
    resetDut();
    applyStimulus(32'hA5A5_5A5A, 1'b1, 1'b1, 0);

    $display("[TB] response stall for 10 cycles");
    applyStimulus($urandom, 1'b0, 1'b0, 10);

    $display("[TB] eight consecutive mismatches into lockout");
    for (int i = 0; i < MAX_FAIL; i++) applyStimulus($urandom, 1'b1, 1'b0, 0);
    lock_ok = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_key   = $urandom;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || key_out !== '0 || locked !== 1'b1)
        lock_ok = 1'b0;
    end
    bus.req_valid = 1'b0;
    checkOutput("lockout_holds",     lock_ok,  1);
    checkOutput("lockout_fail_cnt",  fail_cnt, MAX_FAIL);
    resetDut();

    $display("[TB] match on fifth query clears miss count");
    for (int i = 0; i < 5; i++) applyStimulus($urandom, 1'b1, (i == 4), 0);

    $display("[TB] reset mid-shift");
    bus.req_valid  = 1'b1;
    bus.req_key    = 32'h1234_5678;
    bus.req_expect = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    repeat (9) tick();
    resetDut();
    applyStimulus(32'h0F0F_1234, 1'b0, 1'b0, 1);

    $display("[TB] all-ones key residency after handshake");
    applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b1, 2);

    $display("[TB] randomized queries");
    for (int i = 0; i < 6; i++)
      applyStimulus($urandom, 1'($urandom), 1'($urandom), int'($urandom_range(3, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
